// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants and bus types for the write-back stage.
package wb_regfile_pkg;

  localparam logic RST_ENABLE    = 1'b0;
  localparam logic RST_DISABLE   = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;
  localparam int REG_NUM    = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      reg_data_t;

  localparam reg_addr_t NOP_REG_ADDR = '0;
  localparam reg_data_t ZERO_WORD    = '0;

endpackage

// File: rtl/wb_regfile_regfile.sv
// 32 x 32 general-purpose register array: one write port, two combinational
// read ports with optional bypass of the pending write.
module regfile
  import wb_regfile_pkg::*;
#(
  parameter int BYPASS = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_data_t wdata,
  input  logic      re1,
  input  reg_addr_t raddr1,
  output reg_data_t rdata1,
  input  logic      re2,
  input  reg_addr_t raddr2,
  output reg_data_t rdata2
);

  reg_data_t regs [REG_NUM];

  // r0 is cleared by reset and never written, so it stays hard zero.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= ZERO_WORD;
      end
    end else if (we == WRITE_ENABLE && waddr != NOP_REG_ADDR) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = ZERO_WORD;
    if (rst == RST_ENABLE || re1 == READ_DISABLE || raddr1 == NOP_REG_ADDR) begin
      rdata1 = ZERO_WORD;
    end else if (BYPASS == 1 && we == WRITE_ENABLE && waddr == raddr1) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = ZERO_WORD;
    if (rst == RST_ENABLE || re2 == READ_DISABLE || raddr2 == NOP_REG_ADDR) begin
      rdata2 = ZERO_WORD;
    end else if (BYPASS == 1 && we == WRITE_ENABLE && waddr == raddr2) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs[raddr2];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB pipeline latch feeding the register file, whose
// write port commits the latch contents one edge after capture.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int BYPASS = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t wd_i,
  input  logic      wreg_i,
  input  reg_data_t wdata_i,
  input  logic      stall_i,
  input  logic      flush_i,
  input  logic      re1_i,
  input  reg_addr_t raddr1_i,
  output reg_data_t rdata1_o,
  input  logic      re2_i,
  input  reg_addr_t raddr2_i,
  output reg_data_t rdata2_o,
  output reg_addr_t wb_wd_o,
  output logic      wb_wreg_o,
  output reg_data_t wb_wdata_o
);

  // Flush outranks stall; the array commits the pre-edge latch either way.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush_i) begin
      wb_wd_o    <= NOP_REG_ADDR;
      wb_wreg_o  <= WRITE_DISABLE;
      wb_wdata_o <= ZERO_WORD;
    end else if (!stall_i) begin
      wb_wd_o    <= wd_i;
      wb_wreg_o  <= wreg_i;
      wb_wdata_o <= wdata_i;
    end
  end

  regfile #(.BYPASS(BYPASS)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_wreg_o),
    .waddr  (wb_wd_o),
    .wdata  (wb_wdata_o),
    .re1    (re1_i),
    .raddr1 (raddr1_i),
    .rdata1 (rdata1_o),
    .re2    (re2_i),
    .raddr2 (raddr2_i),
    .rdata2 (rdata2_o)
  );

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back end of the integer pipeline: receives the destination address, write-enable and result from the `mem` stage, registers them in the MEM/WB pipeline latch, and commits them to the 32 x 32-bit general-purpose register file on the following edge. It also provides the two combinational read ports used by the decode stage, with optional same-cycle bypass of the pending write-back. The block closes the `wd`/`wreg`/`wdata` interface driven by `mem`.

## Interface
Parameters:
- `BYPASS`, default 1: 1 = read ports return the pending MEM/WB result on an address match; 0 = read ports return array contents only.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-low (`RstEnable` = 1'b0).
- `wd_i`  in  5  destination register address from `mem`.
- `wreg_i`  in  1  write enable from `mem`.
- `wdata_i`  in  32  result data from `mem`.
- `stall_i`  in  1  hold the MEM/WB latch.
- `flush_i`  in  1  replace the MEM/WB latch contents with a bubble.
- `re1_i`  in  1  read-port-1 enable.
- `raddr1_i`  in  5  read-port-1 address.
- `rdata1_o`  out  32  read-port-1 data (combinational).
- `re2_i`  in  1  read-port-2 enable.
- `raddr2_i`  in  5  read-port-2 address.
- `rdata2_o`  out  32  read-port-2 data (combinational).
- `wb_wd_o`  out  5  MEM/WB latched address (used by decode forwarding and hazard logic).
- `wb_wreg_o`  out  1  MEM/WB latched write enable.
- `wb_wdata_o`  out  32  MEM/WB latched data.

## Operation
- MEM/WB latch. Priority at each edge: rst low > flush_i > stall_i > capture.
  - rst low: wd = `NOPRegAddr` (0), wreg = `WriteDisable`, wdata = `ZeroWord`.
  - flush_i: load the same bubble values.
  - stall_i: hold the current values.
  - otherwise: capture wd_i, wreg_i and wdata_i.
- Register array, 32 entries.
  - rst low: all entries cleared to 0.
  - Otherwise, when the pre-edge latch has wreg=1 and wd≠0, write wdata to entry wd.
  - Writes to r0 are discarded; r0 always reads 0.
- Writes use the latch contents present before the edge. A flush or stall applied at the same edge does not cancel the commit of the current latch contents.
- While stalled, the latch holds and the same write repeats each cycle. This is idempotent and permitted.
- Read port n (identical logic for both ports), in priority order:
  1. rst low → 0.
  2. re=0 → 0.
  3. raddr=0 → 0.
  4. BYPASS=1, wb_wreg=1 and wb_wd=raddr → wb_wdata.
  5. Otherwise → array[raddr].
- The two ports are fully independent. Both may read the same address, including the bypassed address.

## Timing
- Edge N: `mem` output captured into the latch; wb_* outputs valid after edge N.
- Edge N+1: value committed to the array.
- Between N and N+1: the value is visible on the read ports only when BYPASS=1. From N+1 onward it is visible from the array regardless of BYPASS.
- Read ports have zero latency (purely combinational from addresses, enables and state).
- Reset values of all outputs: wb_wd_o=0, wb_wreg_o=0, wb_wdata_o=0, rdata1_o=0, rdata2_o=0.
- Reset asserted mid-operation: the pending latch write is discarded at that edge, and both the array and the latch are cleared.
- flush_i and stall_i asserted together: flush wins.

## Structure
- Shared defines package holds:
  - `RstEnable`/`RstDisable`, `WriteEnable`/`WriteDisable`, `ReadEnable`/`ReadDisable`
  - `RegAddrBus` [4:0], `RegBus` [31:0], `RegNum` 32
  - `NOPRegAddr`, `ZeroWord`
- Natural split:
  - sub-module `regfile`: array, write port and both read ports with bypass;
  - `wb_regfile`: the MEM/WB latch plus an instance of `regfile`.

## Test plan
- Reset: hold rst low 2 cycles with wreg_i=1, wd_i=5, wdata_i=32'hDEAD_BEEF → all outputs 0; after release, a read of r5 (re1_i=1) returns 0.
- Basic write-back and latency: wd_i=3, wreg_i=1, wdata_i=32'h1234_5678 for one cycle, then idle.
  - BYPASS=1: rdata1_o for raddr1_i=3 equals 32'h1234_5678 in the cycle after capture.
  - BYPASS=0: the same read returns the old value until one further edge.
- r0 protection: write 32'hFFFF_FFFF to r0 → both read ports return 0 for raddr=0, including during the bypass window.
- Flush versus stall: latch holds {wd=7, data=32'hA5A5_A5A5}; assert flush_i and stall_i together with new input {wd=8, data=1}.
  - r7 = 32'hA5A5_A5A5 (the pre-edge latch contents commit).
  - wb_wreg_o = 0 after the edge.
  - r8 unchanged.
- Stall hold: stall_i=1 for 3 cycles with changing inputs → wb_* outputs stable at the captured values; the target register holds that value.
- Dual read with disable: raddr1_i = raddr2_i = 9 (r9 = 32'h0000_0042), re1_i=1, re2_i=0 → rdata1_o = 32'h42, rdata2_o = 0.
